fpmult_arbiter: RTL and testbench
=================================

// Module: fpmult_arbiter
// PURPOSE
//  Shares one fpmult instance between NREQ requesters. Requests are granted
//  round-robin, and only one multiplication is in flight at a time.
//  Per requester, the block does a valid/ready request handshake and a
//  valid/ready response handshake. On the multiplier side it drives
//  start/operands and collects p/oor/valid. A watchdog detects a hung multiply.
// PARAMETERS
//  P        8   integer bits of fixed-point operand (passed through to fpmult)
//  Q        8   fraction bits of operand; W = P+Q is the operand width
//  NREQ     4   number of requesters (>=2)
//  TIMEOUT  64  max cycles in WAIT before forced error response (>=2)
// PORTS
//  clk_in         in   1          clock, all logic on rising edge
//  rst_in         in   1          asynchronous active-high reset
//  req_valid_in   in   NREQ       requester i has an operation pending
//  req_ready_out  out  NREQ       one-hot accept pulse to requester i
//  req_x_in       in   NREQ*W     operand X of requester i at [i*W +: W]
//  req_y_in       in   NREQ*W     operand Y of requester i at [i*W +: W]
//  req_round_in   in   NREQ*2     rounding mode of requester i at [i*2 +: 2]
//  rsp_valid_out  out  NREQ       one-hot: result for requester i available
//  rsp_ready_in   in   NREQ       requester i consumes result
//  rsp_p_out      out  W          result (shared bus, qualified by rsp_valid_out)
//  rsp_oor_out    out  4          out-of-range vector of result
//  fpm_x_out      out  W          operand X to fpmult
//  fpm_y_out      out  W          operand Y to fpmult
//  fpm_round_out  out  2          rounding mode to fpmult
//  fpm_start_out  out  1          one-cycle start pulse to fpmult
//  fpm_ready_in   in   1          fpmult ready_out
//  fpm_valid_in   in   1          fpmult valid_out
//  fpm_p_in       in   W          fpmult p_out
//  fpm_oor_in     in   4          fpmult oor_out
//  grant_out      in/out: out  $clog2(NREQ)  index of current/last grant
//  busy_out       out  1          1 in any state other than IDLE
//  timeout_out    out  1          one-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, last_grant=NREQ-1 (req 0 has first
//   priority), every output and operand/result register = 0.
//  IDLE: if fpm_ready_in && |req_valid_in:
//   - g = first set req_valid_in index searching last_grant+1 .. wrapping mod NREQ
//   - req_ready_out[g]=1 for exactly this cycle (combinational from state/valids)
//   - latch x,y,round of g into fpm_*_out regs; grant_out<=g; -> ISSUE
//   If fpm_ready_in=0, nothing is granted and req_ready_out=0.
//  ISSUE: fpm_start_out=1 for one cycle when fpm_ready_in=1, then -> WAIT.
//   Otherwise hold in ISSUE. fpm_*_out stay stable from latch until leaving WAIT.
//  WAIT: watchdog counter increments each cycle from 0.
//   - fpm_valid_in=1 -> latch fpm_p_in/fpm_oor_in into rsp regs; -> RESP
//   - counter==TIMEOUT-1 without valid -> rsp_p=0, rsp_oor=4'hF,
//     timeout_out pulse; -> RESP
//   - valid and timeout in the same cycle: valid wins, no timeout pulse
//  RESP: rsp_valid_out[grant_out]=1, held with rsp_p/oor stable until
//   rsp_ready_in[grant_out]=1. On that cycle: last_grant<=grant_out; -> IDLE.
//   rsp_ready_in of other requesters is ignored.
//  fpm_valid_in outside WAIT is ignored. req_valid_in changing while not in
//   IDLE has no effect.
//  Latency: grant -> start = 1 cycle (with fpm_ready_in high). A new grant can
//   occur on the cycle after the response handshake. Minimum turnaround is
//   4 + fpmult latency.
//  Fairness: a requester that holds valid is granted within NREQ operations.
//  No request queueing: at most one operation is accepted and outstanding.
// TESTING
//  1 Single req: req0 x=16'h0200 y=16'h0300 rnd=0 -> one req_ready_out[0] pulse.
//    Start pulses 1 cycle later. rsp_valid_out[0] returns the fpmult result
//    16'h0600, oor=0.
//  2 All 4 valid continuously after reset -> grants in order 0,1,2,3,0.
//    Exactly one start per grant. Each rsp goes to the matching index only.
//  3 Backpressure: hold rsp_ready_in[1]=0 for 10 cycles -> rsp_valid_out[1],
//    p and oor stay stable. No new grant. req_ready_out stays 0 throughout.
//  4 Model fpmult never asserting valid -> after TIMEOUT(64) cycles in WAIT:
//    timeout_out pulse, rsp p=0, oor=4'hF. Arbiter then returns to IDLE.
//  5 fpm_ready_in=0 with req pending -> no grant and no start. Raise
//    fpm_ready_in -> grant the next cycle.
//  6 Assert rst_in mid-WAIT (async, off-edge) -> all outputs 0 immediately.
//    Next grant after release goes to req 0.

Source files
------------

// File: rtl/fpmult_arbiter_if.sv
// Bundle of every requester-side and multiplier-side signal of the fpmult
// arbiter. The arbiter connects through the slave modport. The environment
// (requesters plus the shared fpmult) connects through the master modport.
//
// Handshake rules:
// - Request: a requester raises req_valid_in[i] and holds its operands
//   until the arbiter accepts it. The acceptance is a one-cycle req_ready_out[i].
// - Response: rsp_valid_out[i] stays high, with rsp_p_out and rsp_oor_out
//   held stable, until the cycle in which rsp_ready_in[i] is high.
// - A transfer completes on a rising clock edge where valid and ready are
//   both high.
interface fpmult_arbiter_if #(
   parameter int P    = 8,
   parameter int Q    = 8,
   parameter int NREQ = 4
) ();
   localparam int W  = P + Q;
   localparam int GW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid_in;
   logic [NREQ-1:0]   req_ready_out;
   logic [NREQ*W-1:0] req_x_in;
   logic [NREQ*W-1:0] req_y_in;
   logic [NREQ*2-1:0] req_round_in;
   logic [NREQ-1:0]   rsp_valid_out;
   logic [NREQ-1:0]   rsp_ready_in;
   logic [W-1:0]      rsp_p_out;
   logic [3:0]        rsp_oor_out;
   logic [W-1:0]      fpm_x_out;
   logic [W-1:0]      fpm_y_out;
   logic [1:0]        fpm_round_out;
   logic              fpm_start_out;
   logic              fpm_ready_in;
   logic              fpm_valid_in;
   logic [W-1:0]      fpm_p_in;
   logic [3:0]        fpm_oor_in;
   logic [GW-1:0]     grant_out;
   logic              busy_out;
   logic              timeout_out;

   modport slave (
      input  req_valid_in, req_x_in, req_y_in, req_round_in, rsp_ready_in,
             fpm_ready_in, fpm_valid_in, fpm_p_in, fpm_oor_in,
      output req_ready_out, rsp_valid_out, rsp_p_out, rsp_oor_out,
             fpm_x_out, fpm_y_out, fpm_round_out, fpm_start_out,
             grant_out, busy_out, timeout_out
   );

   modport master (
      output req_valid_in, req_x_in, req_y_in, req_round_in, rsp_ready_in,
             fpm_ready_in, fpm_valid_in, fpm_p_in, fpm_oor_in,
      input  req_ready_out, rsp_valid_out, rsp_p_out, rsp_oor_out,
             fpm_x_out, fpm_y_out, fpm_round_out, fpm_start_out,
             grant_out, busy_out, timeout_out
   );
endinterface

// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter that shares one fpmult between NREQ requesters.
// Only one multiplication is in flight at a time. A watchdog turns a hung
// multiply into an error response (p=0, oor=4'hF).
module fpmult_arbiter #(
   parameter int P       = 8,
   parameter int Q       = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic            clk_in,
   input  logic            rst_in,
   output logic [1:0]      state_out,
   fpmult_arbiter_if.slave bus
);
   localparam int W  = P + Q;
   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [W-1:0]    x_q, x_d;
   logic [W-1:0]    y_q, y_d;
   logic [1:0]      round_q, round_d;
   logic [W-1:0]    rsp_p_q, rsp_p_d;
   logic [3:0]      rsp_oor_q, rsp_oor_d;
   logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   logic [GW-1:0]   pick;
   logic [GW-1:0]   cand;
   logic            pick_found;
   logic [NREQ-1:0] req_ready;
   logic [NREQ-1:0] rsp_valid;

   // Round-robin search: first valid requester after the last one served.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(last_grant_q) + k) % NREQ);
         if (!pick_found && bus.req_valid_in[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // Accept pulse and response valid, both one-hot and derived from state.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_q == S_IDLE && bus.fpm_ready_in && pick_found && !rst_in) begin
         req_ready[pick] = 1'b1;
      end
      if (state_q == S_RESP) begin
         rsp_valid[grant_q] = 1'b1;
      end
   end

   // Next-state logic for the grant / issue / wait / respond sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      x_d          = x_q;
      y_d          = y_q;
      round_d      = round_q;
      rsp_p_d      = rsp_p_q;
      rsp_oor_d    = rsp_oor_q;
      wd_cnt_d     = wd_cnt_q;
      timeout_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.fpm_ready_in && pick_found) begin
               x_d     = bus.req_x_in[int'(pick)*W +: W];
               y_d     = bus.req_y_in[int'(pick)*W +: W];
               round_d = bus.req_round_in[int'(pick)*2 +: 2];
               grant_d = pick;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // The start pulse goes out this cycle, so the watchdog begins from 0.
            if (bus.fpm_ready_in) begin
               wd_cnt_d = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // A result that arrives on the last watchdog cycle still counts as a
            // normal result.
            if (bus.fpm_valid_in) begin
               rsp_p_d   = bus.fpm_p_in;
               rsp_oor_d = bus.fpm_oor_in;
               state_d   = S_RESP;
            end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_p_d   = '0;
               rsp_oor_d = 4'hF;
               timeout_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready_in[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         last_grant_q <= GW'(NREQ - 1);
         grant_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         round_q      <= '0;
         rsp_p_q      <= '0;
         rsp_oor_q    <= '0;
         wd_cnt_q     <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         x_q          <= x_d;
         y_q          <= y_d;
         round_q      <= round_d;
         rsp_p_q      <= rsp_p_d;
         rsp_oor_q    <= rsp_oor_d;
         wd_cnt_q     <= wd_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.req_ready_out = req_ready;
   assign bus.rsp_valid_out = rsp_valid;
   assign bus.rsp_p_out     = rsp_p_q;
   assign bus.rsp_oor_out   = rsp_oor_q;
   assign bus.fpm_x_out     = x_q;
   assign bus.fpm_y_out     = y_q;
   assign bus.fpm_round_out = round_q;
   assign bus.fpm_start_out = (state_q == S_ISSUE) && bus.fpm_ready_in;
   assign bus.grant_out     = grant_q;
   assign bus.busy_out      = (state_q != S_IDLE);
   assign bus.timeout_out   = timeout_q;
   assign state_out         = state_q;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Directed bench for fpmult_arbiter. A behavioural fpmult returns the
// Q8.8 product after a programmable latency, or hangs on request.
module tb_fpmult_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state;

   always #5 clk = ~clk;

   fpmult_arbiter_if #(.P(8), .Q(8), .NREQ(4)) bus ();

   fpmult_arbiter #(.P(8), .Q(8), .NREQ(4), .TIMEOUT(64)) dut (
      .clk_in    (clk),
      .rst_in    (rst),
      .state_out (state),
      .bus       (bus)
   );

   int n_cmp     = 0;
   int n_err     = 0;
   int start_cnt = 0;

   // behavioural fpmult
   logic        fpm_rdy;
   logic        m_hang;
   logic        m_busy = 1'b0;
   int          m_lat;
   int          m_cnt;
   logic        s_start;
   logic [15:0] s_x, s_y, m_x, m_y;
   logic [31:0] prod;

   assign bus.fpm_ready_in = fpm_rdy & ~m_busy;

   initial begin : fpm_model
      m_cnt            = 0;
      bus.fpm_valid_in = 1'b0;
      bus.fpm_p_in     = '0;
      bus.fpm_oor_in   = '0;
      forever begin
         @(negedge clk);
         s_start = bus.fpm_start_out;
         s_x     = bus.fpm_x_out;
         s_y     = bus.fpm_y_out;
         @(posedge clk);
         #1;
         bus.fpm_valid_in = 1'b0;
         if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else if (m_busy) begin
            if (m_cnt <= 1) begin
               m_busy = 1'b0;
               if (!m_hang) begin
                  prod             = {16'd0, m_x} * {16'd0, m_y};
                  bus.fpm_valid_in = 1'b1;
                  bus.fpm_p_in     = prod[23:8];
                  bus.fpm_oor_in   = 4'h0;
               end
            end else begin
               m_cnt = m_cnt - 1;
            end
         end else if (s_start) begin
            m_busy = 1'b1;
            m_cnt  = m_lat;
            m_x    = s_x;
            m_y    = s_y;
         end
      end
   end

   initial begin : start_monitor
      forever begin
         @(negedge clk);
         if (bus.fpm_start_out === 1'b1) start_cnt++;
      end
   end

   initial begin : time_limit
      #300000;
      $display("FAIL time_limit: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait for the accept pulse of idx, then check the issue cycle.
   task automatic issue(input int idx, input logic [15:0] ex, input logic [15:0] ey,
                        input logic keep, output int waited);
      int n = 0;
      @(negedge clk);
      while (bus.req_ready_out == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      check($sformatf("g%0d_ready", idx), 32'(bus.req_ready_out), 32'(1) << idx);
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid_in[idx] = 1'b0;
      @(negedge clk);
      check($sformatf("g%0d_start", idx), 32'(bus.fpm_start_out), 32'd1);
      check($sformatf("g%0d_x", idx), 32'(bus.fpm_x_out), 32'(ex));
      check($sformatf("g%0d_y", idx), 32'(bus.fpm_y_out), 32'(ey));
      check($sformatf("g%0d_round", idx), 32'(bus.fpm_round_out), 32'(idx));
      check($sformatf("g%0d_grant", idx), 32'(bus.grant_out), 32'(idx));
      check($sformatf("g%0d_ready_clr", idx), 32'(bus.req_ready_out), 32'd0);
   endtask

   // Wait for the response and check it.
   task automatic collect(input int idx, input logic [15:0] ep, input logic [3:0] eo);
      int n = 0;
      while (bus.rsp_valid_out == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("r%0d_valid", idx), 32'(bus.rsp_valid_out), 32'(1) << idx);
      check($sformatf("r%0d_p", idx), 32'(bus.rsp_p_out), 32'(ep));
      check($sformatf("r%0d_oor", idx), 32'(bus.rsp_oor_out), 32'(eo));
   endtask

   task automatic ack(input int idx);
      bus.rsp_ready_in[idx] = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready_in = '0;
   endtask

   task automatic serve(input int idx, input logic [15:0] ex, input logic [15:0] ey,
                        input logic [15:0] ep, input logic keep, output int waited);
      issue(idx, ex, ey, keep, waited);
      collect(idx, ep, 4'h0);
      ack(idx);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int   w;
      int   n;
      int   s0;
      logic to_seen;

      rst              = 1'b1;
      fpm_rdy          = 1'b1;
      m_hang           = 1'b0;
      m_lat            = 2;
      bus.req_valid_in = '0;
      bus.rsp_ready_in = '0;
      bus.req_x_in     = {16'h0400, 16'h0300, 16'h0200, 16'h0200};
      bus.req_y_in     = {16'h0200, 16'h0200, 16'h0200, 16'h0300};
      bus.req_round_in = {2'd3, 2'd2, 2'd1, 2'd0};

      // reset state
      @(negedge clk);
      check("rst_busy", 32'(bus.busy_out), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_grant", 32'(bus.grant_out), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
      check("rst_start", 32'(bus.fpm_start_out), 32'd0);
      check("rst_timeout", 32'(bus.timeout_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: single request, 2.0 * 3.0 = 6.0
      bus.req_valid_in = 4'b0001;
      serve(0, 16'h0200, 16'h0300, 16'h0600, 1'b0, w);
      bus.req_x_in[15:0] = 16'h0100;
      bus.req_y_in[15:0] = 16'h0200;

      // 2: all requesters valid after reset -> 0,1,2,3,0
      do_reset();
      bus.req_valid_in = 4'b1111;
      s0 = start_cnt;
      serve(0, 16'h0100, 16'h0200, 16'h0200, 1'b1, w);
      serve(1, 16'h0200, 16'h0200, 16'h0400, 1'b1, w);
      serve(2, 16'h0300, 16'h0200, 16'h0600, 1'b1, w);
      serve(3, 16'h0400, 16'h0200, 16'h0800, 1'b1, w);
      serve(0, 16'h0100, 16'h0200, 16'h0200, 1'b1, w);
      bus.req_valid_in = '0;
      check("t2_starts", 32'(start_cnt - s0), 32'd5);

      // 3: response backpressure while others request
      bus.req_valid_in = 4'b0010;
      issue(1, 16'h0200, 16'h0200, 1'b0, w);
      collect(1, 16'h0400, 4'h0);
      @(posedge clk);
      #1;
      bus.req_valid_in = 4'b0101;
      repeat (10) begin
         @(negedge clk);
         check("t3_rsp_valid", 32'(bus.rsp_valid_out), 32'b0010);
         check("t3_p", 32'(bus.rsp_p_out), 32'h0400);
         check("t3_oor", 32'(bus.rsp_oor_out), 32'h0);
         check("t3_no_grant", 32'(bus.req_ready_out), 32'd0);
      end
      ack(1);
      serve(2, 16'h0300, 16'h0200, 16'h0600, 1'b0, w);
      serve(0, 16'h0100, 16'h0200, 16'h0200, 1'b0, w);

      // 4: hung multiply -> watchdog after 64 WAIT cycles
      m_hang = 1'b1;
      bus.req_valid_in = 4'b1000;
      issue(3, 16'h0400, 16'h0200, 1'b0, w);
      n = 0;
      while (bus.timeout_out !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_latency", 32'(n), 32'd65);
      collect(3, 16'h0000, 4'hF);
      check("t4_grant", 32'(bus.grant_out), 32'd3);
      @(negedge clk);
      check("t4_pulse_end", 32'(bus.timeout_out), 32'd0);
      check("t4_rsp_hold", 32'(bus.rsp_valid_out), 32'b1000);
      ack(3);
      @(negedge clk);
      check("t4_idle", 32'(bus.busy_out), 32'd0);
      m_hang = 1'b0;

      // 4b: result on the last watchdog cycle wins over the timeout
      m_lat = 63;
      @(posedge clk);
      #1;
      bus.req_valid_in = 4'b0010;
      issue(1, 16'h0200, 16'h0200, 1'b0, w);
      n       = 0;
      to_seen = 1'b0;
      while (bus.rsp_valid_out == '0 && n < 200) begin
         @(negedge clk);
         n++;
         to_seen = to_seen | bus.timeout_out;
      end
      check("t4b_latency", 32'(n), 32'd65);
      check("t4b_no_timeout", 32'(to_seen), 32'd0);
      collect(1, 16'h0400, 4'h0);
      ack(1);
      m_lat = 2;

      // 5: multiplier not ready -> no grant until it is
      fpm_rdy          = 1'b0;
      bus.req_valid_in = 4'b0100;
      s0               = start_cnt;
      repeat (5) begin
         @(negedge clk);
         check("t5_no_grant", 32'(bus.req_ready_out), 32'd0);
         check("t5_busy", 32'(bus.busy_out), 32'd0);
      end
      check("t5_no_start", 32'(start_cnt - s0), 32'd0);
      @(posedge clk);
      #1;
      fpm_rdy = 1'b1;
      serve(2, 16'h0300, 16'h0200, 16'h0600, 1'b0, w);
      check("t5_grant_delay", 32'(w), 32'd0);

      // 6: asynchronous reset in the middle of WAIT
      m_lat = 20;
      bus.req_valid_in = 4'b1000;
      issue(3, 16'h0400, 16'h0200, 1'b0, w);
      repeat (3) @(negedge clk);
      check("t6_pre_busy", 32'(bus.busy_out), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_state", 32'(state), 32'd0);
      check("t6_busy", 32'(bus.busy_out), 32'd0);
      check("t6_x", 32'(bus.fpm_x_out), 32'd0);
      check("t6_y", 32'(bus.fpm_y_out), 32'd0);
      check("t6_round", 32'(bus.fpm_round_out), 32'd0);
      check("t6_grant", 32'(bus.grant_out), 32'd0);
      check("t6_start", 32'(bus.fpm_start_out), 32'd0);
      check("t6_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
      check("t6_rsp_p", 32'(bus.rsp_p_out), 32'd0);
      check("t6_rsp_oor", 32'(bus.rsp_oor_out), 32'd0);
      check("t6_req_ready", 32'(bus.req_ready_out), 32'd0);
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      m_lat = 2;
      @(posedge clk);
      #1;
      bus.req_valid_in = 4'b1111;
      serve(0, 16'h0100, 16'h0200, 16'h0200, 1'b1, w);
      bus.req_valid_in = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
